// File: rtl/fifo_enq_arbiter.sv
// Burst-fair arbiter feeding a single-entry downstream FIFO.
// Grant is combinational; ownership state lets one requester take up to BURST
// consecutive transfers before the round-robin pointer moves on.
module fifo_enq_arbiter #(
  parameter int width = 32,
  parameter int NREQ  = 4,
  parameter int BURST = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_enq_ena,
  input  logic [NREQ*width-1:0]    req_enq_v,
  output logic [NREQ-1:0]          req_enq_rdy,
  output logic                     out_enq_ena,
  output logic [width-1:0]         out_enq_v,
  input  logic                     out_enq_rdy,
  output logic [$clog2(NREQ)-1:0]  out_tag
);

  localparam int TW = $clog2(NREQ);
  localparam logic [TW:0]   NREQ_W  = (TW+1)'(NREQ);
  localparam logic [TW-1:0] LAST_W  = TW'(NREQ - 1);
  localparam logic [3:0]    BURST_W = 4'(BURST);

  logic [TW-1:0] ptr_r;
  logic          owner_valid_r;
  logic [TW-1:0] owner_r;
  logic [3:0]    cnt_r;

  logic          found_s;
  logic [TW-1:0] grant_s;
  logic          xfer_s;
  logic [TW:0]   sum_s;
  logic [TW-1:0] idx_s;

  function automatic logic [TW-1:0] wrap_inc(input logic [TW-1:0] x);
    logic [TW-1:0] r;
    if (x == LAST_W) begin
      r = {TW{1'b0}};
    end else begin
      r = x + TW'(1);
    end
    return r;
  endfunction

  // Grant selection: a live owner wins, else first requester from ptr upward.
  always_comb begin
    found_s = 1'b0;
    grant_s = {TW{1'b0}};
    sum_s   = {(TW+1){1'b0}};
    idx_s   = {TW{1'b0}};
    if (owner_valid_r && req_enq_ena[owner_r]) begin
      found_s = 1'b1;
      grant_s = owner_r;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        sum_s = {1'b0, ptr_r} + (TW+1)'(k);
        if (sum_s >= NREQ_W) begin
          idx_s = TW'(sum_s - NREQ_W);
        end else begin
          idx_s = sum_s[TW-1:0];
        end
        if (!found_s && req_enq_ena[idx_s]) begin
          found_s = 1'b1;
          grant_s = idx_s;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  assign xfer_s = found_s & out_enq_rdy;

  // Output steering: value, tag and the one-hot accept go to the granted requester.
  always_comb begin
    out_enq_ena = xfer_s;
    out_enq_v   = {width{1'b0}};
    req_enq_rdy = {NREQ{1'b0}};
    if (found_s) begin
      out_tag = grant_s;
    end else begin
      out_tag = {TW{1'b0}};
    end
    for (int i = 0; i < NREQ; i++) begin
      if (found_s && (grant_s == TW'(i))) begin
        out_enq_v      = req_enq_v[i*width +: width];
        req_enq_rdy[i] = out_enq_rdy;
      end else begin
        req_enq_rdy[i] = 1'b0;
      end
    end
  end

  // Ownership / burst state update; a stall with the owner still asking holds everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_r         <= {TW{1'b0}};
      owner_valid_r <= 1'b0;
      owner_r       <= {TW{1'b0}};
      cnt_r         <= 4'd0;
    end else if (xfer_s) begin
      if (owner_valid_r && (grant_s == owner_r)) begin
        if ((cnt_r + 4'd1) == BURST_W) begin
          owner_valid_r <= 1'b0;
          cnt_r         <= 4'd0;
          ptr_r         <= wrap_inc(grant_s);
        end else begin
          cnt_r <= cnt_r + 4'd1;
        end
      end else if (BURST == 1) begin
        ptr_r         <= wrap_inc(grant_s);
        owner_valid_r <= 1'b0;
        cnt_r         <= 4'd0;
      end else begin
        owner_r       <= grant_s;
        owner_valid_r <= 1'b1;
        cnt_r         <= 4'd1;
      end
    end else if (owner_valid_r && !req_enq_ena[owner_r]) begin
      ptr_r         <= wrap_inc(owner_r);
      owner_valid_r <= 1'b0;
      cnt_r         <= 4'd0;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Bench for fifo_enq_arbiter (width=8, NREQ=4, BURST=2): directed scenarios
// plus random traffic, all checked against an integer-level reference model.
module tb_fifo_enq_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] ena;
  logic [N*W-1:0] vals;
  logic [N-1:0] req_rdy;
  logic         out_ena;
  logic [W-1:0] out_v;
  logic         out_rdy;
  logic [1:0]   tag;

  int tests;
  int fails;

  int m_ptr;
  int m_ov;
  int m_owner;
  int m_cnt;

  fifo_enq_arbiter #(.width(W), .NREQ(N), .BURST(B)) dut (
    .CLK         (clk),
    .RST         (rst),
    .req_enq_ena (ena),
    .req_enq_v   (vals),
    .req_enq_rdy (req_rdy),
    .out_enq_ena (out_ena),
    .out_enq_v   (out_v),
    .out_enq_rdy (out_rdy),
    .out_tag     (tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] e);
    if (m_ov != 0 && e[m_owner]) return m_owner;
    for (int k = 0; k < N; k++) begin
      if (e[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock: drive, check combinational outputs, clock, advance the model.
  task automatic cyc(input logic r, input logic [N-1:0] e, input logic [31:0] v,
                     input logic rd, input int xtag);
    int g;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] exp_v;
    rst = r; ena = e; vals = v; out_rdy = rd;
    #2;
    g = model_grant(e);
    exp_rdy = 4'b0000;
    exp_v   = 8'h00;
    if (g >= 0) begin
      exp_v = v[g*W +: W];
      if (rd) exp_rdy = 4'b0001 << g;
    end
    if (!r) begin
      check("out_ena", 32'(out_ena), 32'((g >= 0) && rd));
      check("tag", 32'(tag), (g >= 0) ? 32'(g) : 32'd0);
      check("out_v", 32'(out_v), 32'(exp_v));
      check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    end
    if (xtag >= 0) check("dir_tag", 32'(tag), 32'(xtag));
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_ov = 0; m_owner = 0; m_cnt = 0;
    end else if (g >= 0 && rd) begin
      if (m_ov != 0 && g == m_owner) begin
        m_cnt++;
        if (m_cnt == B) begin
          m_ov = 0; m_cnt = 0; m_ptr = (g + 1) % N;
        end
      end else if (B == 1) begin
        m_ptr = (g + 1) % N; m_ov = 0;
      end else begin
        m_owner = g; m_ov = 1; m_cnt = 1;
      end
    end else if (m_ov != 0 && !e[m_owner]) begin
      m_ptr = (m_owner + 1) % N; m_ov = 0; m_cnt = 0;
    end
    #1;
  endtask

  int seq030 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int seq031 [5] = '{0, 2, 2, 0, 0};

  initial begin
    tests = 0; fails = 0;
    m_ptr = 0; m_ov = 0; m_owner = 0; m_cnt = 0;
    rst = 1'b1; ena = '0; vals = '0; out_rdy = 1'b0;

    cyc(1'b1, 4'b0000, 32'h0, 1'b0, -1);
    cyc(1'b1, 4'b0000, 32'h0, 1'b1, -1);
    // idle after reset: everything zero
    cyc(1'b0, 4'b0000, 32'h44332211, 1'b1, 0);

    // all requesting: two-beat bursts rotate
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'b1111, 32'hD4C3B2A1, 1'b1, seq030[i]);

    cyc(1'b1, 4'b0000, 32'h0, 1'b0, -1);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, (i == 1) ? 4'b0100 : 4'b0101, 32'h99887766, 1'b1, seq031[i]);

    // downstream stall holds a single requester, then one transfer
    cyc(1'b1, 4'b0000, 32'h0, 1'b0, -1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0010, 32'h0000A500, 1'b0, 1);
    cyc(1'b0, 4'b0010, 32'h0000A500, 1'b1, 1);
    check("stall_v_ok", {31'd0, m_ov[0]}, 32'd1);
    cyc(1'b0, 4'b1111, 32'h0000A500, 1'b1, 1);
    cyc(1'b0, 4'b1111, 32'h0000A500, 1'b1, 2);

    // pointer wraps 3 -> 0
    cyc(1'b1, 4'b0000, 32'h0, 1'b0, -1);
    cyc(1'b0, 4'b1000, 32'h11000000, 1'b1, 3);
    cyc(1'b0, 4'b1000, 32'h22000000, 1'b1, 3);
    cyc(1'b0, 4'b1001, 32'h330000EE, 1'b1, 0);

    // reset mid-burst with owner 2 overrides the concurrent transfer
    cyc(1'b1, 4'b0000, 32'h0, 1'b0, -1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'b1111, 32'h01020304, 1'b1, -1);
    check("pre_rst_owner", 32'(m_owner), 32'd2);
    cyc(1'b1, 4'b1111, 32'h01020304, 1'b1, -1);
    cyc(1'b0, 4'b1111, 32'h01020304, 1'b1, 0);

    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)),
          $urandom, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_enq_arbiter.md
FIFO_ENQ_ARBITER -- requirements
Module: fifo_enq_arbiter

Interface
REQ-001 Parameter width, default 32, SHALL set the data width of every enqueue value.
REQ-002 Parameter NREQ, default 4, range 2..8, SHALL set the number of requesters.
REQ-003 Parameter BURST, default 2, range 1..15, SHALL set the maximum consecutive transfers granted to one requester.
REQ-004 CLK  input  1  SHALL be the only clock; all state updates on its rising edge.
REQ-005 RST  input  1  SHALL be the synchronous, active-high reset.
REQ-006 req$enq__ENA  input  NREQ  SHALL carry the per-requester enqueue request; bit i belongs to requester i.
REQ-007 req$enq$v  input  NREQ*width  SHALL carry the per-requester value; slice [i*width +: width] belongs to requester i.
REQ-008 req$enq__RDY  output  NREQ  SHALL mark the requester whose value is accepted this cycle.
REQ-009 out$enq__ENA  output  1  SHALL drive the downstream single-entry FIFO enqueue enable.
REQ-010 out$enq$v  output  width  SHALL drive the downstream enqueue value.
REQ-011 out$enq__RDY  input  1  SHALL be the downstream FIFO ready, meaning not full.
REQ-012 out$tag  output  clog2(NREQ)  SHALL give the index of the granted requester; 0 when none.

Function
REQ-013 State SHALL be: ptr (clog2(NREQ) bits), owner_valid (1), owner (clog2(NREQ)), cnt (4 bits).
REQ-014 Grant g: if owner_valid and req$enq__ENA[owner], then g = owner; otherwise g = the first i with ENA[i] set, scanning ptr, ptr+1, ... modulo NREQ.
REQ-015 Grant SHALL be combinational; with no ENA bit set, no grant exists.
REQ-016 out$enq__ENA SHALL equal (a grant exists) AND out$enq__RDY.
REQ-017 When a grant exists, out$enq$v SHALL equal req$enq$v slice g and out$tag SHALL equal g; otherwise both SHALL be 0.
REQ-018 req$enq__RDY[i] SHALL be 1 only for i == g and only when out$enq__RDY = 1; at most one bit is ever set.
REQ-019 Transfer SHALL occur in a cycle where out$enq__ENA = 1; exactly one value moves per transfer, with zero added latency.
REQ-020 Transfer by the current owner (owner_valid and g == owner):
- cnt increments.
- If cnt+1 == BURST: owner_valid clears, cnt clears, ptr = (g+1) mod NREQ.
REQ-021 Transfer by a non-owner g:
- If BURST == 1: ptr = (g+1) mod NREQ, owner_valid stays 0.
- Else: owner = g, owner_valid = 1, cnt = 1.
REQ-022 Owner drops request (owner_valid and ENA[owner] = 0):
- ptr = (owner+1) mod NREQ, owner_valid clears, cnt clears.
- If a non-owner transfers in the same cycle, REQ-021 SHALL take precedence for owner, owner_valid and cnt, and ptr SHALL follow REQ-021.
REQ-023 Downstream stall (grant exists, out$enq__RDY = 0): state SHALL hold; the owner keeps ownership while its ENA stays high.
REQ-024 ptr SHALL wrap modulo NREQ, including for non-power-of-two NREQ.
REQ-025 RDY outputs SHALL depend combinationally on ENA inputs; no output SHALL feed back into any input path inside the block.

Reset
REQ-026 On RST = 1 at a clock edge: ptr = 0, owner_valid = 0, owner = 0, cnt = 0.
REQ-027 RST SHALL override any concurrent transfer; a transfer signalled during the reset cycle SHALL not update state.
REQ-028 After reset with all ENA low, all outputs SHALL be 0.

Verification
All scenarios use width = 8, NREQ = 4, BURST = 2.
REQ-029 Reset, then ENA = 4'b0000 -> out$enq__ENA = 0, req$enq__RDY = 0, out$tag = 0.
REQ-030 ENA = 4'b1111 held, out$enq__RDY = 1 for 8 cycles -> tag sequence 0,0,1,1,2,2,3,3.
REQ-031 ENA = 4'b0101, out$enq__RDY = 1, requester 0 drops after its 1st transfer -> tags 0,2,2,0,0.
REQ-032 ENA = 4'b0010, v1 = 8'hA5, out$enq__RDY low 3 cycles then high -> RDY[1] = 0 during the stall, then one transfer with out$enq$v = 8'hA5; ptr then remains 0 (owner_valid = 1, cnt = 1).
REQ-033 ENA = 4'b1000 with two transfers, then ENA = 4'b1001 -> grant 0 (ptr wrapped 3 -> 0).
REQ-034 RST asserted mid-burst (owner = 2, cnt = 1) with ENA = 4'b1111 -> next grant 0.
